hls_run_sequencer: RTL and testbench

Run controller for a Bambu-generated accelerator top that exposes the start_port/done_port/return_port minimal interface. On a host command it runs the accelerator N times. Each run gets a fresh accelerator reset, a one-cycle start pulse and a watchdog. The sequencer captures the return value and the cycle count of each run and hands them out on a valid/ready result port. It sits between the host/CSR layer and the accelerator instance, replacing the behavioural sequencing done in simulation benches.

---
 rtl/hls_run_sequencer.sv | 136 +++++++++++++
 tb/tb_hls_run_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
// Runs a Bambu start/done accelerator N times per host command: a fresh reset, a start pulse and a watchdog for each run.
// Each run's return value and latency come out on a valid/ready result port; the accelerator is held idle while the consumer stalls.
module hls_run_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_runs,
    output logic              acc_reset,
    output logic              acc_start,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_return,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              res_timeout,
    output logic              busy,
    output logic              batch_done,
    output logic [CNT_W-1:0]  runs_done
);
    typedef enum logic [2:0] {IDLE, RST, START, WAIT, PUSH} state_t;

    localparam int unsigned      RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUNS_MAX  = '1;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [RC_W-1:0]  rst_cnt;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_inc;

    // cyc_inc is the latency of the current run if it finishes in this cycle.
    assign cyc_inc = cyc + CYC_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            acc_reset   <= 1'b1;
            acc_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
            batch_done  <= 1'b0;
            runs_done   <= '0;
            remaining   <= '0;
            rst_cnt     <= '0;
            cyc         <= '0;
        end else begin
            batch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        remaining <= cmd_runs;
                        runs_done <= '0;
                        if (cmd_runs == '0) begin
                            batch_done <= 1'b1;
                        end else begin
                            state     <= RST;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            rst_cnt   <= '0;
                        end
                    end
                end
                RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state     <= START;
                        acc_reset <= 1'b0;
                        acc_start <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RC_ONE;
                    end
                end
                START: begin
                    acc_start <= 1'b0;
                    cyc       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the watchdog's last cycle still counts as a real result.
                    if (acc_done) begin
                        res_data    <= acc_return;
                        res_cycles  <= cyc_inc;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        remaining   <= remaining - CNT_ONE;
                        if (runs_done != RUNS_MAX) begin
                            runs_done <= runs_done + CNT_ONE;
                        end
                        state <= PUSH;
                    end else if (cyc_inc == CYC_LIMIT) begin
                        res_data    <= '0;
                        res_cycles  <= CYC_LIMIT;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        remaining   <= '0;
                        state       <= PUSH;
                    end else begin
                        cyc <= cyc_inc;
                    end
                end
                PUSH: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        acc_reset <= 1'b1;
                        if (remaining != '0) begin
                            state   <= RST;
                            rst_cnt <= '0;
                        end else begin
                            state      <= IDLE;
                            cmd_ready  <= 1'b1;
                            busy       <= 1'b0;
                            batch_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer: a behavioural accelerator replies after a per-run latency taken from a table.
module tb_hls_run_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_runs;
    logic        acc_reset;
    logic        acc_start;
    logic        acc_done = 1'b0;
    logic [31:0] acc_return = '0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] res_cycles;
    logic        res_timeout;
    logic        busy;
    logic        batch_done;
    logic [7:0]  runs_done;

    int tests_run = 0;
    int tests_failed = 0;

    int          lat_tab [0:7];
    logic [31:0] ret_tab [0:7];
    int          base = 0;
    logic        glitch = 1'b0;
    int          starts = 0;
    int          rst_seen = 0;
    int          bd_seen = 0;
    int          r0, b0;

    hls_run_sequencer #(
        .DATA_W(32), .CYC_W(32), .CNT_W(8), .TIMEOUT(16), .RST_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
        .acc_reset(acc_reset), .acc_start(acc_start), .acc_done(acc_done), .acc_return(acc_return),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cycles(res_cycles), .res_timeout(res_timeout),
        .busy(busy), .batch_done(batch_done), .runs_done(runs_done)
    );

    always #5 clock = ~clock;

    // Accelerator model and event monitor, evaluated mid-cycle.
    initial begin
        int cd;
        int idx;
        logic act;
        logic [31:0] ret_cur;
        cd = 0; act = 1'b0; ret_cur = '0;
        forever begin
            @(negedge clock);
            acc_done = 1'b0;
            if (busy && acc_reset) rst_seen++;
            if (batch_done) bd_seen++;
            if (acc_start) begin
                idx = (starts - base) & 7;
                starts++;
                cd = lat_tab[idx];
                ret_cur = ret_tab[idx];
                act = (cd != 0);
                if (glitch) begin
                    acc_done = 1'b1;
                    acc_return = 32'h99;
                end
            end else if (act) begin
                cd--;
                if (cd == 0) begin
                    acc_done = 1'b1;
                    acc_return = ret_cur;
                    act = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] n);
        int w = 0;
        cmd_valid = 1'b1;
        cmd_runs = n;
        while (!cmd_ready && w < 50) begin tick(); w++; end
        check("cmd_ready_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_result(input string tn, input int stall, input logic [31:0] ed,
                              input logic [31:0] ec, input logic et);
        int w = 0;
        res_ready = 1'b0;
        while (!res_valid && w < 100) begin tick(); w++; end
        check({tn, "_valid"}, res_valid, 1);
        check({tn, "_data"}, res_data, ed);
        check({tn, "_cycles"}, res_cycles, ec);
        check({tn, "_timeout"}, res_timeout, et);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tn, "_stall_valid"}, res_valid, 1);
            check({tn, "_stall_data"}, res_data, ed);
            check({tn, "_stall_start"}, acc_start, 0);
            check({tn, "_stall_reset"}, acc_reset, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tn, "_drop"}, res_valid, 0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_runs = '0; res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin lat_tab[i] = 0; ret_tab[i] = '0; end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_acc_reset", acc_reset, 1);
        check("rst_acc_start", acc_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_cycles", res_cycles, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_batch_done", batch_done, 0);
        check("rst_runs_done", runs_done, 0);

        // Single run
        lat_tab[0] = 5; ret_tab[0] = 32'h2A;
        base = starts; r0 = rst_seen; b0 = bd_seen;
        send_cmd(1);
        get_result("t1", 0, 32'd42, 32'd5, 1'b0);
        check("t1_batch_done", batch_done, 1);
        check("t1_runs_done", runs_done, 1);
        check("t1_busy", busy, 0);
        tick();
        check("t1_bd_one_cycle", batch_done, 0);
        tick();
        check("t1_starts", starts - base, 1);
        check("t1_rst_cycles", rst_seen - r0, 2);
        check("t1_bd_count", bd_seen - b0, 1);

        // Three runs, consumer stalls on the second result
        lat_tab[0] = 3; ret_tab[0] = 32'd7;
        lat_tab[1] = 4; ret_tab[1] = 32'd8;
        lat_tab[2] = 3; ret_tab[2] = 32'd9;
        base = starts; r0 = rst_seen;
        send_cmd(3);
        get_result("t2a", 0, 32'd7, 32'd3, 1'b0);
        get_result("t2b", 4, 32'd8, 32'd4, 1'b0);
        get_result("t2c", 0, 32'd9, 32'd3, 1'b0);
        check("t2_batch_done", batch_done, 1);
        check("t2_runs_done", runs_done, 3);
        repeat (2) tick();
        check("t2_starts", starts - base, 3);
        check("t2_rst_cycles", rst_seen - r0, 6);

        // Zero-run batch
        base = starts; b0 = bd_seen;
        send_cmd(0);
        check("t3_batch_done", batch_done, 1);
        check("t3_runs_done", runs_done, 0);
        check("t3_busy", busy, 0);
        repeat (3) tick();
        check("t3_starts", starts - base, 0);
        check("t3_bd_count", bd_seen - b0, 1);

        // Watchdog aborts the rest of a four-run batch
        lat_tab[0] = 0; ret_tab[0] = 32'hDEAD;
        base = starts;
        send_cmd(4);
        get_result("t4", 0, 32'd0, 32'd16, 1'b1);
        check("t4_batch_done", batch_done, 1);
        check("t4_runs_done", runs_done, 0);
        repeat (3) tick();
        check("t4_starts", starts - base, 1);

        // Done lands on the last watchdog cycle
        lat_tab[0] = 16; ret_tab[0] = 32'h55;
        base = starts;
        send_cmd(1);
        get_result("t5", 0, 32'h55, 32'd16, 1'b0);
        check("t5_runs_done", runs_done, 1);

        // Done raised during START is ignored
        glitch = 1'b1;
        lat_tab[0] = 3; ret_tab[0] = 32'h77;
        base = starts;
        send_cmd(1);
        get_result("t6", 0, 32'h77, 32'd3, 1'b0);
        glitch = 1'b0;
        repeat (2) tick();
        check("t6_starts", starts - base, 1);

        // Reset during the second run of three
        lat_tab[0] = 3; ret_tab[0] = 32'h31;
        lat_tab[1] = 20; ret_tab[1] = 32'h32;
        lat_tab[2] = 3; ret_tab[2] = 32'h33;
        base = starts;
        send_cmd(3);
        get_result("t7a", 0, 32'h31, 32'd3, 1'b0);
        for (int w = 0; w < 20 && (starts - base) < 2; w++) tick();
        repeat (3) tick();
        check("t7_in_wait", busy, 1);
        b0 = bd_seen;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_busy", busy, 0);
        check("t7_acc_reset", acc_reset, 1);
        check("t7_res_valid", res_valid, 0);
        check("t7_runs_done", runs_done, 0);
        check("t7_batch_done", batch_done, 0);
        check("t7_cmd_ready", cmd_ready, 1);
        lat_tab[0] = 2; ret_tab[0] = 32'h11;
        base = starts;
        send_cmd(1);
        get_result("t7b", 0, 32'h11, 32'd2, 1'b0);
        check("t7_bd_count", bd_seen - b0, 0);
        check("t7_runs_after", runs_done, 1);

        // Back-to-back commands with cmd_valid held high
        lat_tab[0] = 2; ret_tab[0] = 32'hA1;
        lat_tab[1] = 2; ret_tab[1] = 32'hA2;
        base = starts;
        cmd_valid = 1'b1;
        cmd_runs = 8'd1;
        tick();
        check("t8_accepted", busy, 1);
        get_result("t8a", 0, 32'hA1, 32'd2, 1'b0);
        check("t8_batch_done", batch_done, 1);
        check("t8_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t8_busy", busy, 1);
        check("t8_acc_reset", acc_reset, 1);
        check("t8_cmd_ready_low", cmd_ready, 0);
        get_result("t8b", 0, 32'hA2, 32'd2, 1'b0);
        check("t8_runs_done", runs_done, 1);
        repeat (2) tick();
        check("t8_starts", starts - base, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
